// File: rtl/key_conditioner_if.sv
// Front-panel key bundle: raw button pins in, debounced levels and press strobes out.
interface key_conditioner_if #(
    parameter int unsigned NUM_KEYS = 2
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_pulse;

    modport master (
        output key_raw,
        input  key_level,
        input  key_pulse
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_pulse
    );
endinterface

// File: rtl/key_conditioner.sv
// Per-key two-flop sync, ms-tick debounce, registered press strobe and optional
// hold-to-repeat for the clock's front-panel buttons.
module key_conditioner #(
    parameter int unsigned          CLK_FREQ_HZ      = 50_000_000,
    parameter int unsigned          NUM_KEYS         = 2,
    parameter bit                   KEY_ACTIVE_LOW   = 1'b1,
    parameter int unsigned          DEBOUNCE_MS      = 20,
    parameter int unsigned          REPEAT_DELAY_MS  = 500,
    parameter int unsigned          REPEAT_PERIOD_MS = 100,
    parameter logic [NUM_KEYS-1:0]  REPEAT_EN        = NUM_KEYS'(1)
) (
    input  logic             sys_clk_i,
    input  logic             ext_rst_n,
    key_conditioner_if.slave key_if
);

    localparam int unsigned TICK_CYCLES = CLK_FREQ_HZ / 1000;
    localparam int unsigned TICK_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned DB_W        = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned REP_MAX     = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ?
                                          REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
    localparam int unsigned REP_W       = $clog2(REP_MAX + 1);
    localparam logic [NUM_KEYS-1:0] RELEASED = {NUM_KEYS{KEY_ACTIVE_LOW}};

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    if (CLK_FREQ_HZ == 0 || (CLK_FREQ_HZ % 1000) != 0) begin : g_bad_clk
        $error("CLK_FREQ_HZ must be a non-zero multiple of 1000");
    end
    if (DEBOUNCE_MS < 2) begin : g_bad_debounce
        $error("DEBOUNCE_MS must be at least 2");
    end
    if (REPEAT_DELAY_MS < 1 || REPEAT_PERIOD_MS < 1) begin : g_bad_repeat
        $error("REPEAT_DELAY_MS and REPEAT_PERIOD_MS must be at least 1");
    end

    logic [TICK_W-1:0]   r_tick_cnt;
    logic                w_ms_tick;
    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] w_pressed;
    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_pulse;

    // Shared millisecond strobe for every key's debounce and repeat timing.
    assign w_ms_tick = (r_tick_cnt == TICK_W'(TICK_CYCLES - 1));

    always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_ms_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            r_sync1 <= RELEASED;
            r_sync2 <= RELEASED;
        end else begin
            r_sync1 <= key_if.key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Internal pressed = 1 regardless of pin polarity.
    assign w_pressed = r_sync2 ^ RELEASED;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [DB_W-1:0]  r_db_cnt;
        logic             r_level;
        logic             r_pulse;
        rep_state_e       r_state;
        logic [REP_W-1:0] r_rep_cnt;
        logic             w_db_done;
        logic             w_level_d;
        logic             w_rise;
        logic             w_rep_fire;

        always_comb begin
            w_db_done  = (w_pressed[i] != r_level) && w_ms_tick &&
                         (r_db_cnt == DB_W'(DEBOUNCE_MS - 1));
            w_level_d  = w_db_done ? ~r_level : r_level;
            w_rise     = w_db_done && !r_level;
            w_rep_fire = 1'b0;
            // A release decided this cycle suppresses any coincident repeat.
            if (w_ms_tick && w_level_d) begin
                if (r_state == StDelay && r_rep_cnt == REP_W'(REPEAT_DELAY_MS - 1)) begin
                    w_rep_fire = 1'b1;
                end else if (r_state == StRepeat &&
                             r_rep_cnt == REP_W'(REPEAT_PERIOD_MS - 1)) begin
                    w_rep_fire = 1'b1;
                end
            end
        end

        always_ff @(posedge sys_clk_i or negedge ext_rst_n) begin
            if (!ext_rst_n) begin
                r_db_cnt  <= '0;
                r_level   <= 1'b0;
                r_pulse   <= 1'b0;
                r_state   <= StIdle;
                r_rep_cnt <= '0;
            end else begin
                r_level <= w_level_d;
                r_pulse <= w_rise | w_rep_fire;

                if (w_pressed[i] == r_level || w_db_done) begin
                    r_db_cnt <= '0;
                end else if (w_ms_tick) begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end

                if (!REPEAT_EN[i] || !w_level_d) begin
                    r_state   <= StIdle;
                    r_rep_cnt <= '0;
                end else begin
                    unique case (r_state)
                        StIdle: begin
                            if (w_rise) begin
                                r_state   <= StDelay;
                                r_rep_cnt <= '0;
                            end
                        end
                        StDelay: begin
                            if (w_rep_fire) begin
                                r_state   <= StRepeat;
                                r_rep_cnt <= '0;
                            end else if (w_ms_tick) begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
                        end
                        StRepeat: begin
                            if (w_rep_fire) begin
                                r_rep_cnt <= '0;
                            end else if (w_ms_tick) begin
                                r_rep_cnt <= r_rep_cnt + 1'b1;
                            end
                        end
                        default: begin
                            r_state   <= StIdle;
                            r_rep_cnt <= '0;
                        end
                    endcase
                end
            end
        end

        assign w_level[i] = r_level;
        assign w_pulse[i] = r_pulse;
    end

    assign key_if.key_level = w_level;
    assign key_if.key_pulse = w_pulse;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboarded bench for key_conditioner: 10-cycle ms tick, 4 ms debounce,
// 20 ms repeat delay, 5 ms repeat period, repeat on key 0 only.
`timescale 1ns/1ps
module tb_key_conditioner;

    localparam int unsigned NK = 2;

    typedef struct {
        int lo;
        int hi;
        bit press;
    } win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulse_count [NK];
    int   last_pulse [NK];
    logic [NK-1:0] prev_level = '0;
    win_t q0[$];
    win_t q1[$];

    key_conditioner_if #(.NUM_KEYS(NK)) dut_if ();

    key_conditioner #(
        .CLK_FREQ_HZ     (10_000),
        .NUM_KEYS        (NK),
        .KEY_ACTIVE_LOW  (1'b1),
        .DEBOUNCE_MS     (4),
        .REPEAT_DELAY_MS (20),
        .REPEAT_PERIOD_MS(5),
        .REPEAT_EN       (2'b01)
    ) dut (
        .sys_clk_i(clk),
        .ext_rst_n(rst_n),
        .key_if   (dut_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed pulse pops the key's next expected window.
    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (dut_if.key_pulse[k] === 1'b1) begin
                win_t w;
                bit   have;
                have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
                pulse_count[k] = pulse_count[k] + 1;
                last_pulse[k] = cyc;
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL unexpected_pulse key%0d: pulse at cycle %0d, required none",
                             k, cyc);
                end else begin
                    if (k == 0) w = q0.pop_front();
                    else w = q1.pop_front();
                    if (cyc < w.lo || cyc > w.hi) begin
                        errors++;
                        $display("FAIL pulse_time key%0d: pulse at cycle %0d, required %0d..%0d",
                                 k, cyc, w.lo, w.hi);
                    end
                    checks++;
                    if (dut_if.key_level[k] !== 1'b1 ||
                        prev_level[k] !== (w.press ? 1'b0 : 1'b1)) begin
                        errors++;
                        $display("FAIL pulse_level key%0d: level %b (was %b), required 1 (was %b)",
                                 k, dut_if.key_level[k], prev_level[k], !w.press);
                    end
                end
            end
            prev_level[k] = dut_if.key_level[k];
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic push(input int k, input int lo, input int hi, input bit press);
        win_t w;
        w.lo = lo;
        w.hi = hi;
        w.press = press;
        if (k == 0) q0.push_back(w);
        else q1.push_back(w);
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic wait_drain(input int k, input int budget, output int left);
        int n = 0;
        while (qsize(k) != 0 && n < budget) begin
            step(1);
            n++;
        end
        left = qsize(k);
        if (k == 0) q0.delete();
        else q1.delete();
    endtask

    task automatic wait_level(input int k, input logic v, input int budget, output int waited);
        int start = cyc;
        while (dut_if.key_level[k] !== v && cyc - start < budget) step(1);
        waited = (dut_if.key_level[k] === v) ? cyc - start : -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            dut_if.key_raw = 2'(i);
            step(1);
            checks++;
            if (dut_if.key_level !== 2'b00 || dut_if.key_pulse !== 2'b00) begin
                errors++;
                $display("FAIL reset_outputs: level %b pulse %b, required 00 00",
                         dut_if.key_level, dut_if.key_pulse);
            end
        end
        dut_if.key_raw = 2'b11;
        rst_n = 1'b1;
        step(1000);
        checks++;
        if (dut_if.key_level !== 2'b00) begin
            errors++;
            $display("FAIL idle_level: level %b, required 00", dut_if.key_level);
        end
        checks++;
        if (pulse_count[0] + pulse_count[1] != 0) begin
            errors++;
            $display("FAIL idle_pulses: %0d pulses, required 0", pulse_count[0] + pulse_count[1]);
        end
    endtask

    task automatic test_clean_press;
        int e, c0, waited, left;
        c0 = pulse_count[1];
        dut_if.key_raw[1] = 1'b0;
        e = cyc;
        push(1, e + 33, e + 43, 1'b1);
        step(300);
        wait_drain(1, 1, left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL clean_press_seen: %0d pulses missing, required 0", left);
        end
        dut_if.key_raw[1] = 1'b1;
        wait_level(1, 1'b0, 100, waited);
        checks++;
        if (waited < 33 || waited > 43) begin
            errors++;
            $display("FAIL clean_release_time: level fell after %0d cycles, required 33..43",
                     waited);
        end
        step(20);
        checks++;
        if (pulse_count[1] - c0 != 1) begin
            errors++;
            $display("FAIL clean_press_count: %0d pulses, required 1", pulse_count[1] - c0);
        end
    endtask

    task automatic test_bounce;
        int e, c0, waited, left, bad;
        c0 = pulse_count[0];
        bad = 0;
        for (int t = 0; t < 8; t++) begin
            dut_if.key_raw[0] = t[0];
            for (int j = 0; j < 15; j++) begin
                step(1);
                if (dut_if.key_level[0] !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_level: level high on %0d bounce cycles, required 0", bad);
        end
        dut_if.key_raw[0] = 1'b0;
        e = cyc;
        push(0, e + 33, e + 43, 1'b1);
        wait_drain(0, 60, left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL bounce_press_seen: %0d pulses missing, required 0", left);
        end
        wait_until(last_pulse[0] + 100);
        dut_if.key_raw[0] = 1'b1;
        wait_level(0, 1'b0, 100, waited);
        step(20);
        checks++;
        if (pulse_count[0] - c0 != 1) begin
            errors++;
            $display("FAIL bounce_count: %0d pulses, required 1", pulse_count[0] - c0);
        end
    endtask

    task automatic test_auto_repeat;
        int e, p, c0, waited, left;
        c0 = pulse_count[0];
        dut_if.key_raw[0] = 1'b0;
        e = cyc;
        push(0, e + 33, e + 43, 1'b1);
        wait_drain(0, 60, left);
        p = last_pulse[0];
        for (int r = 0; r < 6; r++) push(0, p + 200 + 50 * r, p + 200 + 50 * r, 1'b0);
        wait_until(p + 455);
        checks++;
        if (left != 0 || qsize(0) != 0) begin
            errors++;
            $display("FAIL repeat_seen: %0d press / %0d repeat pulses missing, required 0 / 0",
                     left, qsize(0));
        end
        q0.delete();
        dut_if.key_raw[0] = 1'b1;
        wait_level(0, 1'b0, 100, waited);
        checks++;
        if (waited < 33 || waited > 43) begin
            errors++;
            $display("FAIL repeat_release_time: level fell after %0d cycles, required 33..43",
                     waited);
        end
        step(300);
        checks++;
        if (pulse_count[0] - c0 != 7) begin
            errors++;
            $display("FAIL repeat_count: %0d pulses, required 7", pulse_count[0] - c0);
        end
    endtask

    task automatic test_repeat_disabled;
        int e, c0, waited, left;
        c0 = pulse_count[1];
        dut_if.key_raw[1] = 1'b0;
        e = cyc;
        push(1, e + 33, e + 43, 1'b1);
        wait_drain(1, 60, left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL norepeat_press_seen: %0d pulses missing, required 0", left);
        end
        wait_until(last_pulse[1] + 500);
        dut_if.key_raw[1] = 1'b1;
        wait_level(1, 1'b0, 100, waited);
        step(20);
        checks++;
        if (pulse_count[1] - c0 != 1) begin
            errors++;
            $display("FAIL norepeat_count: %0d pulses, required 1", pulse_count[1] - c0);
        end
    endtask

    task automatic test_simultaneous;
        int e, waited, left0, left1;
        dut_if.key_raw = 2'b00;
        e = cyc;
        push(0, e + 33, e + 43, 1'b1);
        push(1, e + 33, e + 43, 1'b1);
        wait_drain(0, 60, left0);
        wait_drain(1, 5, left1);
        checks++;
        if (left0 != 0 || left1 != 0 || last_pulse[0] != last_pulse[1]) begin
            errors++;
            $display("FAIL simultaneous: pulses at %0d / %0d (missing %0d/%0d), required equal",
                     last_pulse[0], last_pulse[1], left0, left1);
        end
        wait_until(last_pulse[0] + 100);
        dut_if.key_raw = 2'b11;
        wait_level(0, 1'b0, 100, waited);
        wait_level(1, 1'b0, 100, waited);
        step(20);
    endtask

    task automatic test_reset_mid_repeat;
        int e, p, q, r, c0, waited, left;
        c0 = pulse_count[0];
        dut_if.key_raw[0] = 1'b0;
        e = cyc;
        push(0, e + 33, e + 43, 1'b1);
        wait_drain(0, 60, left);
        p = last_pulse[0];
        push(0, p + 200, p + 200, 1'b0);
        push(0, p + 250, p + 250, 1'b0);
        wait_until(p + 270);
        checks++;
        if (left != 0 || qsize(0) != 0) begin
            errors++;
            $display("FAIL midrst_before: %0d / %0d pulses missing, required 0 / 0",
                     left, qsize(0));
        end
        q0.delete();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dut_if.key_level !== 2'b00 || dut_if.key_pulse !== 2'b00) begin
            errors++;
            $display("FAIL midrst_outputs: level %b pulse %b, required 00 00",
                     dut_if.key_level, dut_if.key_pulse);
        end
        step(5);
        rst_n = 1'b1;
        r = cyc;
        push(0, r + 33, r + 43, 1'b1);
        wait_drain(0, 60, left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL midrst_press_seen: %0d pulses missing, required 0", left);
        end
        q = last_pulse[0];
        push(0, q + 200, q + 200, 1'b0);
        wait_drain(0, 260, left);
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL midrst_repeat_seen: %0d pulses missing, required 0", left);
        end
        dut_if.key_raw[0] = 1'b1;
        wait_level(0, 1'b0, 100, waited);
        step(100);
        checks++;
        if (pulse_count[0] - c0 != 5) begin
            errors++;
            $display("FAIL midrst_count: %0d pulses, required 5", pulse_count[0] - c0);
        end
    endtask

    initial begin
        for (int k = 0; k < NK; k++) begin
            pulse_count[k] = 0;
            last_pulse[k] = 0;
        end
        dut_if.key_raw = 2'b11;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_repeat_disabled();
        test_simultaneous();
        test_reset_mid_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
